riscv_fetch_queue: RTL and testbench

Instruction fetch stage directly upstream of the U-type field decoder. Generates sequential PCs and issues word requests to instruction memory over a valid/ready port. Buffers in-order responses with their PCs in a small FIFO and presents them to the decode stage over a valid/ready port. Supports a redirect input, used for jumps, branches and traps, that flushes all buffered and in-flight instructions.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/riscv_fetch_fifo.sv | 58 +++++
 rtl/riscv_fetch_queue.sv | 122 ++++++++++++
 tb/tb_riscv_fetch_queue.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and defaults
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INST_W       = 32;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [INST_W-1:0]       inst;
        logic [XLEN_DEFAULT-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// rtl/riscv_fetch_fifo.sv - synchronous FIFO of fetch entries; flush beats push and pop
module riscv_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is reset so the head reads as zero before the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/riscv_fetch_queue.sv
// rtl/riscv_fetch_queue.sv - fetch PC/credit/drop logic; FETCH_STALL_CNT_EN adds stall_cnt
module riscv_fetch_queue
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            req_valid_q, req_valid_d;
    logic [CW-1:0]   count, count_next;
    logic            accept, push, pop;
    logic [XLEN-1:0] redirect_tgt;
    fetch_entry_t    push_entry, head;

    always_comb begin
        accept        = req_valid_q && imem_req_ready;
        push          = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
        pop           = (count != '0) && inst_ready && !redirect_valid;
        redirect_tgt  = redirect_pc & ~XLEN'(3);
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        count_next    = count + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            // Everything still in flight after this edge is stale, including a same-cycle accept.
            pc_d       = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            drop_cnt_d = outstanding_d;
            count_next = '0;
        end else begin
            if (accept) pc_d = pc_q + XLEN'(4);
            if (push)   rsp_pc_d = rsp_pc_q + XLEN'(4);
            if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
        end
        req_valid_d = ({1'b0, count_next} + {1'b0, outstanding_d}) < (CW + 1)'(DEPTH);
        push_entry.inst = imem_rsp_data;
        push_entry.pc   = XLEN_DEFAULT'(rsp_pc_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            req_valid_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            req_valid_q   <= req_valid_d;
        end
    end

    riscv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (count != '0);
    assign inst           = head.inst;
    assign inst_pc        = XLEN'(head.pc);

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((inst_valid && !inst_ready) || (req_valid_q && !imem_req_ready)) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(imem_rsp_valid && (outstanding_q == '0)));
    end
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb/tb_riscv_fetch_queue.sv - directed self-checking bench for riscv_fetch_queue
module tb_riscv_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] s0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    logic        hold;
    logic [31:0] pend[$];
    logic [31:0] acc_log[$];
    int          acc_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];

    always #5 clk = ~clk;

    riscv_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0537 + (a >> 2) * 32'h80;
    endfunction

    // One clock: record accepts/pops before the edge, then memory answers after it.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        if (inst_valid && inst_ready && !redirect_valid) begin
            pop_pc.push_back(inst_pc);
            pop_inst.push_back(inst);
        end
        if (acc) begin
            acc_log.push_back(a);
            acc_cyc.push_back(cyc_n);
        end
        @(posedge clk);
        if (acc) pend.push_back(a);
        @(negedge clk);
        cyc_n++;
        imem_rsp_valid = 1'b0;
        if (!hold && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend.pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; hold = 1'b0;
        pend.delete(); acc_log.delete(); acc_cyc.delete(); pop_pc.delete(); pop_inst.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL rst_req_addr got=%h exp=00000000", imem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=00000000", inst); end
        checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst_pc got=%h exp=00000000", inst_pc); end
        rst_n = 1'b1;
        cyc();
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL rst_first_req got=%b exp=1", imem_req_valid); end
    endtask

    task automatic test_sequential();
        logic found;
        do_reset();
        imem_req_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (!found && inst_valid) begin
                found = 1'b1;
                checks++; if (inst !== 32'h0000_0537) begin failures++; $display("FAIL seq_first_inst got=%h exp=00000537", inst); end
                checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL seq_first_pc got=%h exp=00000000", inst_pc); end
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL seq_inst_valid_timeout got=%b exp=1", found); end
        checks++; if (acc_log.size() !== 4) begin failures++; $display("FAIL full_accept_count got=%0d exp=4", acc_log.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (acc_log[i] !== 32'(i * 4)) begin failures++; $display("FAIL seq_req_addr%0d got=%h exp=%h", i, acc_log[i], 32'(i * 4)); end
        end
        checks++; if (acc_cyc[3] - acc_cyc[0] !== 3) begin failures++; $display("FAIL seq_back_to_back got=%0d exp=3", acc_cyc[3] - acc_cyc[0]); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL full_req_valid got=%b exp=0", imem_req_valid); end
        inst_ready = 1'b1;
        run(10);
        checks++; if (pop_pc.size() < 5) begin failures++; $display("FAIL drain_pop_count got=%0d exp>=5", pop_pc.size()); end
        for (int i = 0; i < 5 && i < pop_pc.size(); i++) begin
            checks++; if (pop_pc[i] !== 32'(i * 4)) begin failures++; $display("FAIL drain_pc%0d got=%h exp=%h", i, pop_pc[i], 32'(i * 4)); end
            checks++; if (pop_inst[i] !== mem_word(32'(i * 4))) begin failures++; $display("FAIL drain_inst%0d got=%h exp=%h", i, pop_inst[i], mem_word(32'(i * 4))); end
        end
        checks++; if (acc_log[4] !== 32'h10) begin failures++; $display("FAIL resume_addr got=%h exp=00000010", acc_log[4]); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        hold = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        run(4);
        imem_req_ready = 1'b0;
        checks++; if (acc_log.size() !== 3) begin failures++; $display("FAIL rd_inflight got=%0d exp=3", acc_log.size()); end
        redirect_valid = 1'b1; redirect_pc = 32'h1000;
        cyc();
        redirect_valid = 1'b0;
        checks++; if (imem_req_addr !== 32'h1000) begin failures++; $display("FAIL rd_req_addr got=%h exp=00001000", imem_req_addr); end
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL rd_req_valid got=%b exp=1", imem_req_valid); end
        hold = 1'b0; imem_req_ready = 1'b1;
        run(12);
        checks++; if (pop_pc[0] !== 32'h1000) begin failures++; $display("FAIL rd_first_pc got=%h exp=00001000", pop_pc[0]); end
        checks++; if (pop_inst[0] !== 32'h0002_0537) begin failures++; $display("FAIL rd_first_inst got=%h exp=00020537", pop_inst[0]); end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        imem_req_ready = 1'b1;
        run(2);
        checks++; if ((imem_req_valid && imem_rsp_valid) !== 1'b1) begin failures++; $display("FAIL sc_setup got=%b exp=1", imem_req_valid && imem_rsp_valid); end
        redirect_valid = 1'b1; redirect_pc = 32'h2000;
        cyc();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL sc_no_push got=%b exp=0", inst_valid); end
        checks++; if (imem_req_addr !== 32'h2000) begin failures++; $display("FAIL sc_req_addr got=%h exp=00002000", imem_req_addr); end
        checks++; if (acc_log.size() !== 2) begin failures++; $display("FAIL sc_accepts got=%0d exp=2", acc_log.size()); end
        cyc();
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL sc_stale_dropped got=%b exp=0", inst_valid); end
        inst_ready = 1'b1;
        run(6);
        checks++; if (pop_pc[0] !== 32'h2000) begin failures++; $display("FAIL sc_first_pc got=%h exp=00002000", pop_pc[0]); end
        checks++; if (pop_inst[0] !== 32'h0004_0537) begin failures++; $display("FAIL sc_first_inst got=%h exp=00040537", pop_inst[0]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        hold = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        run(3);
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        cyc();
        redirect_pc = 32'h4000;
        cyc();
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL b2b_credit_full got=%b exp=0", imem_req_valid); end
        checks++; if (acc_log.size() !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", acc_log.size()); end
        hold = 1'b0;
        run(15);
        checks++; if (pop_pc[0] !== 32'h4000) begin failures++; $display("FAIL b2b_first_pc got=%h exp=00004000", pop_pc[0]); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        run(2);
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL wrap_start_addr got=%h exp=00000000", imem_req_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h1003;
        cyc();
        redirect_valid = 1'b0;
        checks++; if (imem_req_addr !== 32'h1000) begin failures++; $display("FAIL align_addr got=%h exp=00001000", imem_req_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top_addr got=%h exp=fffffffc", imem_req_addr); end
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        cyc();
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr got=%h exp=00000000", imem_req_addr); end
        run(8);
        checks++; if (pop_pc[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pop_pc0 got=%h exp=fffffffc", pop_pc[0]); end
        checks++; if (pop_inst[0] !== 32'h0000_04B7) begin failures++; $display("FAIL wrap_pop_inst0 got=%h exp=000004b7", pop_inst[0]); end
        checks++; if (pop_pc[1] !== 32'h0) begin failures++; $display("FAIL wrap_pop_pc1 got=%h exp=00000000", pop_pc[1]); end
        checks++; if (pop_inst[1] !== 32'h0000_0537) begin failures++; $display("FAIL wrap_pop_inst1 got=%h exp=00000537", pop_inst[1]); end
    endtask

    task automatic test_stall_reset();
        do_reset();
        imem_req_ready = 1'b1;
        run(6);
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stall_nonempty got=%b exp=1", inst_valid); end
`ifdef FETCH_STALL_CNT_EN
        s0 = stall_cnt;
        run(10);
        checks++; if (stall_cnt - s0 !== 32'd10) begin failures++; $display("FAIL stall_delta got=%0d exp=10", stall_cnt - s0); end
`else
        run(10);
`endif
        #2;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        pend.delete();
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL async_rst_inst_valid got=%b exp=0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL async_rst_req_valid got=%b exp=0", imem_req_valid); end
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL async_rst_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_back_to_back();
        test_pc_wrap();
        test_stall_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
